axi_rd_router: RTL and testbench

AXI_RD_ROUTER -- requirements
Module: axi_rd_router

---
 rtl/axi_rd_router.sv | 162 ++++++++++++++++
 tb/tb_axi_rd_router.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_router.sv
// -----------------------------------------------------------------------------
// axi_rd_router
//   Single-outstanding AXI read router. Sits between four read masters and one
//   slave. An external arbiter supplies a grant vector. A granted master's AR is
//   captured and then replayed to the slave. The resulting R burst is steered
//   back to that master only, with zero added latency.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   rgrnt[3:0]            read grant from arbiter (must be one-hot to accept)
//   m_AR*                 per-master AR channel (packed, slice i = master i)
//   m_R*                  R channel back to masters (data/resp/last broadcast,
//                         valid per master, ready per master)
//   s_AR*, s_R*           slave-side AR/R channel
//   arb_*                 handshake feedback to the arbiter
//   err                   sticky burst-length protocol error
// -----------------------------------------------------------------------------
module axi_rd_router #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [3:0]             rgrnt,
  input  logic [3:0]             m_ARVALID,
  input  logic [3:0][ADDR_W-1:0] m_ARADDR,
  input  logic [3:0][LEN_W-1:0]  m_ARLEN,
  output logic [3:0]             m_ARREADY,
  output logic [DATA_W-1:0]      m_RDATA,
  output logic [1:0]             m_RRESP,
  output logic                   m_RLAST,
  output logic [3:0]             m_RVALID,
  input  logic [3:0]             m_RREADY,
  output logic [ADDR_W-1:0]      s_ARADDR,
  output logic [LEN_W-1:0]       s_ARLEN,
  output logic                   s_ARVALID,
  input  logic                   s_ARREADY,
  input  logic [DATA_W-1:0]      s_RDATA,
  input  logic [1:0]             s_RRESP,
  input  logic                   s_RLAST,
  input  logic                   s_RVALID,
  output logic                   s_RREADY,
  output logic                   arb_ARREADY,
  output logic                   arb_RVALID,
  output logic                   arb_RREADY,
  output logic                   arb_RLAST,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, AR_HOLD, R_BURST} state_e;

  state_e              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [LEN_W-1:0]    len_q,   len_d;
  logic [LEN_W-1:0]    cnt_q,   cnt_d;
  logic                err_q,   err_d;

  logic                gnt_onehot;
  logic [1:0]          gnt_idx;
  logic                cnt_zero;
  logic                r_hs;

  // Only a strictly one-hot grant selects a master; zero or multi-hot is a
  // no-accept condition.
  assign gnt_onehot = (rgrnt != 4'd0) && ((rgrnt & (rgrnt - 4'd1)) == 4'd0);
  assign cnt_zero   = (cnt_q == '0);

  always_comb begin
    gnt_idx = 2'd0;
    case (rgrnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    m_ARREADY = 4'd0;
    s_ARVALID = 1'b0;
    m_RVALID  = 4'd0;
    s_RREADY  = 1'b0;
    m_RLAST   = 1'b0;
    m_RDATA   = '0;
    m_RRESP   = 2'd0;
    r_hs      = 1'b0;

    // Handshake outputs are forced low while reset is held, whatever the
    // registered state happens to be.
    if (!ARESET) begin
      case (state_q)
        IDLE: begin
          if (gnt_onehot) m_ARREADY = rgrnt & m_ARVALID;
          if (m_ARREADY != 4'd0) begin
            owner_d = gnt_idx;
            addr_d  = m_ARADDR[gnt_idx];
            len_d   = m_ARLEN[gnt_idx];
            state_d = AR_HOLD;
          end
        end
        AR_HOLD: begin
          s_ARVALID = 1'b1;
          if (s_ARREADY) begin
            cnt_d   = len_q;
            state_d = R_BURST;
          end
        end
        R_BURST: begin
          m_RVALID[owner_q] = s_RVALID;
          s_RREADY          = m_RREADY[owner_q];
          m_RDATA           = s_RDATA;
          m_RRESP           = s_RRESP;
          // Burst ends on whichever comes first: slave's RLAST or our count
          // running out. A disagreement between the two is a protocol error.
          m_RLAST           = s_RLAST | cnt_zero;
          r_hs              = s_RVALID & s_RREADY;
          if (r_hs) begin
            if (!cnt_zero) cnt_d = cnt_q - LEN_W'(1);
            if (s_RLAST != cnt_zero) err_d = 1'b1;
            if (m_RLAST) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign s_ARADDR    = addr_q;
  assign s_ARLEN     = len_q;
  assign err         = err_q;
  assign arb_ARREADY = |m_ARREADY;
  assign arb_RVALID  = |m_RVALID;
  assign arb_RREADY  = s_RREADY;
  assign arb_RLAST   = m_RLAST;

endmodule

// File: tb/tb_axi_rd_router.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_router
//   Directed self-checking bench for axi_rd_router. Inputs change 1ns after
//   the rising edge and outputs are sampled 2ns after it.
// -----------------------------------------------------------------------------
module tb_axi_rd_router;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [3:0]       rgrnt;
  logic [3:0]       m_ARVALID;
  logic [3:0][31:0] m_ARADDR;
  logic [3:0][7:0]  m_ARLEN;
  logic [3:0]       m_ARREADY;
  logic [31:0]      m_RDATA;
  logic [1:0]       m_RRESP;
  logic             m_RLAST;
  logic [3:0]       m_RVALID;
  logic [3:0]       m_RREADY;
  logic [31:0]      s_ARADDR;
  logic [7:0]       s_ARLEN;
  logic             s_ARVALID;
  logic             s_ARREADY;
  logic [31:0]      s_RDATA;
  logic [1:0]       s_RRESP;
  logic             s_RLAST;
  logic             s_RVALID;
  logic             s_RREADY;
  logic             arb_ARREADY, arb_RVALID, arb_RREADY, arb_RLAST;
  logic             err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  axi_rd_router #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .rgrnt(rgrnt),
    .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN),
    .m_ARREADY(m_ARREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP),
    .m_RLAST(m_RLAST), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY),
    .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARVALID(s_ARVALID),
    .s_ARREADY(s_ARREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .arb_ARREADY(arb_ARREADY), .arb_RVALID(arb_RVALID),
    .arb_RREADY(arb_RREADY), .arb_RLAST(arb_RLAST), .err(err)
  );

  // Advance one clock; returns 1ns after the edge, ready for new inputs.
  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rgrnt = 4'd0; m_ARVALID = 4'd0; m_ARADDR = '0; m_ARLEN = '0;
    m_RREADY = 4'd0; s_ARREADY = 1'b0; s_RDATA = '0; s_RRESP = 2'd0;
    s_RLAST = 1'b0; s_RVALID = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1'b1;
    rgrnt = 4'b0001; m_ARVALID = 4'b0001; s_RVALID = 1'b1; m_RREADY = 4'hF;
    s_ARREADY = 1'b1;
    step(); step(); settle();
    n_chk++; if (m_ARREADY !== 4'd0) begin n_fail++; $display("FAIL rst_arready got=%b exp=0000", m_ARREADY); end
    n_chk++; if (s_ARVALID !== 1'b0) begin n_fail++; $display("FAIL rst_s_arvalid got=%b exp=0", s_ARVALID); end
    n_chk++; if (m_RVALID !== 4'd0) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=0000", m_RVALID); end
    n_chk++; if (s_RREADY !== 1'b0) begin n_fail++; $display("FAIL rst_s_rready got=%b exp=0", s_RREADY); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
    n_chk++; if (s_ARADDR !== 32'd0) begin n_fail++; $display("FAIL rst_araddr got=%h exp=0", s_ARADDR); end
    idle_inputs();
    ARESET = 1'b0;
    step();
  endtask

  // Basic 4-beat burst to master 1.
  task automatic test_basic_burst();
    m_ARVALID = 4'b0010; m_ARADDR[1] = 32'h1000_0010; m_ARLEN[1] = 8'd3;
    s_ARREADY = 1'b1; m_RREADY = 4'b0010;
    // Grant points at master 2, which is not requesting: nothing accepted.
    rgrnt = 4'b0100; settle();
    n_chk++; if (m_ARREADY !== 4'd0) begin n_fail++; $display("FAIL basic_wrong_grant got=%b exp=0000", m_ARREADY); end
    rgrnt = 4'b0010; settle();
    n_chk++; if (m_ARREADY !== 4'b0010) begin n_fail++; $display("FAIL basic_arready got=%b exp=0010", m_ARREADY); end
    n_chk++; if (arb_ARREADY !== 1'b1) begin n_fail++; $display("FAIL basic_arb_arready got=%b exp=1", arb_ARREADY); end
    n_chk++; if (s_ARVALID !== 1'b0) begin n_fail++; $display("FAIL basic_s_arvalid_early got=%b exp=0", s_ARVALID); end
    step();
    m_ARVALID = 4'd0; settle();
    n_chk++; if (s_ARVALID !== 1'b1) begin n_fail++; $display("FAIL basic_s_arvalid got=%b exp=1", s_ARVALID); end
    n_chk++; if (s_ARADDR !== 32'h1000_0010) begin n_fail++; $display("FAIL basic_araddr got=%h exp=10000010", s_ARADDR); end
    n_chk++; if (s_ARLEN !== 8'd3) begin n_fail++; $display("FAIL basic_arlen got=%0d exp=3", s_ARLEN); end
    n_chk++; if (m_ARREADY !== 4'd0) begin n_fail++; $display("FAIL basic_arready_hold got=%b exp=0000", m_ARREADY); end
    step();
    s_ARREADY = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_RVALID = 1'b1; s_RDATA = 32'hA0 + b; s_RRESP = 2'(b); s_RLAST = (b == 3);
      settle();
      n_chk++; if (m_RVALID !== 4'b0010) begin n_fail++; $display("FAIL basic_rvalid b%0d got=%b exp=0010", b, m_RVALID); end
      n_chk++; if (m_RDATA !== 32'hA0 + b) begin n_fail++; $display("FAIL basic_rdata b%0d got=%h exp=%h", b, m_RDATA, 32'hA0 + b); end
      n_chk++; if (m_RRESP !== 2'(b)) begin n_fail++; $display("FAIL basic_rresp b%0d got=%0d exp=%0d", b, m_RRESP, b); end
      n_chk++; if (m_RLAST !== (b == 3)) begin n_fail++; $display("FAIL basic_rlast b%0d got=%b exp=%b", b, m_RLAST, b == 3); end
      n_chk++; if ({s_RREADY, arb_RVALID, arb_RREADY, arb_RLAST} !== {1'b1, 1'b1, 1'b1, b == 3}) begin
        n_fail++; $display("FAIL basic_fb b%0d got=%b exp=111%b", b, {s_RREADY, arb_RVALID, arb_RREADY, arb_RLAST}, b == 3); end
      step();
    end
    // Back in IDLE: a stray slave beat must be ignored.
    s_RLAST = 1'b0; settle();
    n_chk++; if (m_RVALID !== 4'd0 || s_RREADY !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after got=%b/%b exp=0000/0", m_RVALID, s_RREADY); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", err); end
    idle_inputs(); step();
  endtask

  task automatic test_ar_stall();
    rgrnt = 4'b0001; m_ARVALID = 4'b0001; m_ARADDR[0] = 32'hDEAD_BEE0; m_ARLEN[0] = 8'd1;
    m_RREADY = 4'hF; s_ARREADY = 1'b0;
    step();
    m_ARVALID = 4'd0; m_ARADDR[0] = 32'h0; m_ARLEN[0] = 8'd9;
    s_RVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      n_chk++; if ({s_ARVALID, s_ARADDR, s_ARLEN} !== {1'b1, 32'hDEAD_BEE0, 8'd1}) begin
        n_fail++; $display("FAIL stall_hold c%0d got=%b/%h/%0d exp=1/deadbee0/1", c, s_ARVALID, s_ARADDR, s_ARLEN); end
      n_chk++; if (s_RREADY !== 1'b0 || m_RVALID !== 4'd0) begin n_fail++; $display("FAIL stall_r_ignored c%0d got=%b/%b exp=0/0000", c, s_RREADY, m_RVALID); end
      step();
    end
    s_ARREADY = 1'b1; settle();
    n_chk++; if (s_ARVALID !== 1'b1) begin n_fail++; $display("FAIL stall_final got=%b exp=1", s_ARVALID); end
    step();
    s_ARREADY = 1'b1; settle();
    n_chk++; if (s_ARVALID !== 1'b0) begin n_fail++; $display("FAIL stall_single_hs got=%b exp=0", s_ARVALID); end
    s_ARREADY = 1'b0;
    s_RLAST = 1'b0; step();
    s_RLAST = 1'b1; settle();
    n_chk++; if (m_RVALID !== 4'b0001 || m_RLAST !== 1'b1) begin n_fail++; $display("FAIL stall_beat2 got=%b/%b exp=0001/1", m_RVALID, m_RLAST); end
    step();
    idle_inputs(); settle();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL stall_err got=%b exp=0", err); end
    step();
  endtask

  task automatic test_multihot();
    m_ARVALID = 4'b0011; rgrnt = 4'b0011; s_ARREADY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_chk++; if (m_ARREADY !== 4'd0 || arb_ARREADY !== 1'b0) begin n_fail++; $display("FAIL multihot_arready c%0d got=%b exp=0000", c, m_ARREADY); end
      step();
      n_chk++; if (s_ARVALID !== 1'b0) begin n_fail++; $display("FAIL multihot_idle c%0d got=%b exp=0", c, s_ARVALID); end
    end
    rgrnt = 4'b0000; settle();
    n_chk++; if (m_ARREADY !== 4'd0) begin n_fail++; $display("FAIL zerogrant got=%b exp=0000", m_ARREADY); end
    idle_inputs(); step();
  endtask

  task automatic test_early_last();
    rgrnt = 4'b0100; m_ARVALID = 4'b0100; m_ARLEN[2] = 8'd3; s_ARREADY = 1'b1; m_RREADY = 4'b0100;
    step();
    m_ARVALID = 4'd0; step();
    s_RVALID = 1'b1; s_RLAST = 1'b0; settle();
    n_chk++; if (m_RLAST !== 1'b0 || m_RVALID !== 4'b0100) begin n_fail++; $display("FAIL early_b1 got=%b/%b exp=0/0100", m_RLAST, m_RVALID); end
    step();
    s_RLAST = 1'b1; settle();
    n_chk++; if (m_RLAST !== 1'b1) begin n_fail++; $display("FAIL early_b2_last got=%b exp=1", m_RLAST); end
    step();
    s_RLAST = 1'b0; settle();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL early_err got=%b exp=1", err); end
    n_chk++; if (m_RVALID !== 4'd0 || s_RREADY !== 1'b0) begin n_fail++; $display("FAIL early_ended got=%b/%b exp=0000/0", m_RVALID, s_RREADY); end
    step(); step(); step();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL early_err_sticky got=%b exp=1", err); end
    idle_inputs(); step();
  endtask

  task automatic test_owner_stable();
    bit rr_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int beat = 0;
    rgrnt = 4'b1000; m_ARVALID = 4'b1000; m_ARLEN[3] = 8'd3; s_ARREADY = 1'b1;
    step();
    m_ARVALID = 4'd0; step();
    s_ARREADY = 1'b0;
    rgrnt = 4'b0001; m_ARVALID = 4'b0001;
    for (int c = 0; c < 8 && beat < 4; c++) begin
      m_RREADY = {rr_pat[c], 3'b111};
      s_RVALID = 1'b1; s_RDATA = 32'h3300 + beat; s_RLAST = (beat == 3);
      settle();
      n_chk++; if (m_RVALID !== 4'b1000) begin n_fail++; $display("FAIL owner_rvalid c%0d got=%b exp=1000", c, m_RVALID); end
      n_chk++; if (s_RREADY !== rr_pat[c]) begin n_fail++; $display("FAIL owner_rready c%0d got=%b exp=%b", c, s_RREADY, rr_pat[c]); end
      n_chk++; if (m_RDATA !== 32'h3300 + beat) begin n_fail++; $display("FAIL owner_rdata c%0d got=%h exp=%h", c, m_RDATA, 32'h3300 + beat); end
      n_chk++; if (m_ARREADY !== 4'd0) begin n_fail++; $display("FAIL owner_no_accept c%0d got=%b exp=0000", c, m_ARREADY); end
      if (rr_pat[c]) beat++;
      step();
    end
    n_chk++; if (beat !== 4) begin n_fail++; $display("FAIL owner_beats got=%0d exp=4", beat); end
    m_ARVALID = 4'd0; s_RLAST = 1'b0; settle();
    n_chk++; if (m_RVALID !== 4'd0) begin n_fail++; $display("FAIL owner_end got=%b exp=0000", m_RVALID); end
    idle_inputs(); step();
  endtask

  task automatic test_reset_mid();
    rgrnt = 4'b0001; m_ARVALID = 4'b0001; m_ARADDR[0] = 32'h0000_7700; m_ARLEN[0] = 8'd7;
    s_ARREADY = 1'b1; m_RREADY = 4'b0001;
    step();
    m_ARVALID = 4'd0; step();
    s_RVALID = 1'b1; step();
    // Reset during beat 2.
    ARESET = 1'b1; settle();
    n_chk++; if ({m_RVALID, s_RREADY, s_ARVALID, m_ARREADY} !== 10'd0) begin
      n_fail++; $display("FAIL rstmid_during got=%b exp=0", {m_RVALID, s_RREADY, s_ARVALID, m_ARREADY}); end
    step();
    ARESET = 1'b0; settle();
    n_chk++; if ({m_RVALID, s_RREADY, s_ARVALID, m_RLAST, err} !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_after got=%b exp=0", {m_RVALID, s_RREADY, s_ARVALID, m_RLAST, err}); end
    n_chk++; if (m_RDATA !== 32'd0 || s_ARADDR !== 32'd0 || s_ARLEN !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_regs got=%h/%h/%0d exp=0/0/0", m_RDATA, s_ARADDR, s_ARLEN); end
    s_RVALID = 1'b0;
    m_ARVALID = 4'b0001; m_ARADDR[0] = 32'h5555_0000; m_ARLEN[0] = 8'd0; settle();
    n_chk++; if (m_ARREADY !== 4'b0001) begin n_fail++; $display("FAIL rstmid_new_ar got=%b exp=0001", m_ARREADY); end
    step();
    m_ARVALID = 4'd0; settle();
    n_chk++; if (s_ARVALID !== 1'b1 || s_ARADDR !== 32'h5555_0000) begin n_fail++; $display("FAIL rstmid_new_s_ar got=%b/%h exp=1/55550000", s_ARVALID, s_ARADDR); end
    step();
    // Single-beat burst where the slave omits RLAST: count ends it, err set.
    s_RVALID = 1'b1; s_RLAST = 1'b0; settle();
    n_chk++; if (m_RLAST !== 1'b1 || m_RVALID !== 4'b0001) begin n_fail++; $display("FAIL rstmid_cnt_last got=%b/%b exp=1/0001", m_RLAST, m_RVALID); end
    step();
    settle();
    n_chk++; if (err !== 1'b1 || m_RVALID !== 4'd0) begin n_fail++; $display("FAIL rstmid_missing_last got=%b/%b exp=1/0000", err, m_RVALID); end
    idle_inputs(); step();
  endtask

  initial begin
    ARESET = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_burst();
    test_ar_stall();
    test_multihot();
    test_early_last();
    test_owner_stable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
